// File: rtl/food_spawn_ctrl.sv
// Apple placement sequencer: samples the random position generator, asks the body checker
// whether the cell is free, retries on a hit and commits the apple (or a fixed fallback).
module food_spawn_ctrl #(
  parameter int unsigned MAX_TRIES  = 8,
  parameter int unsigned RETRY_GAP  = 3,
  parameter int unsigned FALLBACK_X = 320,
  parameter int unsigned FALLBACK_Y = 240,
  parameter int unsigned X_MIN      = 20,
  parameter int unsigned X_MAX      = 620,
  parameter int unsigned Y_MIN      = 20,
  parameter int unsigned Y_MAX      = 460
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic [9:0] rand_Pos,
  input  logic [8:0] rand_Y,
  input  logic       start,
  input  logic       eaten,
  input  logic       clear,
  output logic [9:0] query_x,
  output logic [8:0] query_y,
  output logic       query_valid,
  input  logic       query_ready,
  input  logic       query_done,
  input  logic       query_hit,
  output logic [9:0] apple_x,
  output logic [8:0] apple_y,
  output logic       apple_valid,
  output logic       busy,
  output logic       fallback_used,
  output logic [7:0] spawn_count
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  // RETRY_GAP is expected to be at least 1.
  localparam int unsigned GapW   = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [TriesW-1:0] TriesMax = TriesW'(MAX_TRIES);
  localparam logic [GapW-1:0]   GapLast  = GapW'(RETRY_GAP - 1);
  localparam logic [9:0]        XMin     = 10'(X_MIN);
  localparam logic [9:0]        XMax     = 10'(X_MAX);
  localparam logic [8:0]        YMin     = 9'(Y_MIN);
  localparam logic [8:0]        YMax     = 9'(Y_MAX);
  localparam logic [9:0]        FbX      = 10'(FALLBACK_X);
  localparam logic [8:0]        FbY      = 9'(FALLBACK_Y);

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StQuery,
    StWait,
    StGap,
    StCommit
  } state_e;

  state_e              state_q, state_d;
  logic [9:0]          query_x_q, query_x_d;
  logic [8:0]          query_y_q, query_y_d;
  logic [TriesW-1:0]   tries_q, tries_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                use_fb_q, use_fb_d;
  logic [9:0]          apple_x_q, apple_x_d;
  logic [8:0]          apple_y_q, apple_y_d;
  logic                apple_valid_q, apple_valid_d;
  logic                fallback_used_q, fallback_used_d;
  logic [7:0]          spawn_count_q, spawn_count_d;

  logic [9:0]          cand_x;
  logic [8:0]          cand_y;

  // Clamp the raw generator sample onto the playfield.
  always_comb begin
    cand_x = rand_Pos;
    if (rand_Pos < XMin) begin
      cand_x = XMin;
    end else if (rand_Pos > XMax) begin
      cand_x = XMax;
    end
    cand_y = rand_Y;
    if (rand_Y < YMin) begin
      cand_y = YMin;
    end else if (rand_Y > YMax) begin
      cand_y = YMax;
    end
  end

  always_comb begin
    state_d         = state_q;
    query_x_d       = query_x_q;
    query_y_d       = query_y_q;
    tries_d         = tries_q;
    gap_d           = gap_q;
    use_fb_d        = use_fb_q;
    apple_x_d       = apple_x_q;
    apple_y_d       = apple_y_q;
    apple_valid_d   = apple_valid_q;
    fallback_used_d = fallback_used_q;
    spawn_count_d   = spawn_count_q;

    if (clear) begin
      // Abort wins over any event or checker response seen this cycle.
      state_d       = StIdle;
      apple_valid_d = 1'b0;
      tries_d       = '0;
      gap_d         = '0;
      use_fb_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !apple_valid_q) begin
            state_d = StSample;
          end else if (eaten && apple_valid_q) begin
            state_d       = StSample;
            apple_valid_d = 1'b0;
          end
        end
        StSample: begin
          query_x_d = cand_x;
          query_y_d = cand_y;
          tries_d   = tries_q + 1'b1;
          state_d   = StQuery;
        end
        StQuery: begin
          if (query_ready) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (query_done) begin
            if (!query_hit) begin
              use_fb_d = 1'b0;
              state_d  = StCommit;
            end else if (tries_q >= TriesMax) begin
              use_fb_d = 1'b1;
              state_d  = StCommit;
            end else begin
              gap_d   = '0;
              state_d = StGap;
            end
          end
        end
        StGap: begin
          // Idle cycles let the free-running generator move to a fresh value.
          if (gap_q == GapLast) begin
            gap_d   = '0;
            state_d = StSample;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        StCommit: begin
          apple_x_d       = use_fb_q ? FbX : query_x_q;
          apple_y_d       = use_fb_q ? FbY : query_y_q;
          apple_valid_d   = 1'b1;
          fallback_used_d = use_fb_q;
          spawn_count_d   = spawn_count_q + 8'd1;
          tries_d         = '0;
          state_d         = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      query_x_q       <= '0;
      query_y_q       <= '0;
      tries_q         <= '0;
      gap_q           <= '0;
      use_fb_q        <= 1'b0;
      apple_x_q       <= '0;
      apple_y_q       <= '0;
      apple_valid_q   <= 1'b0;
      fallback_used_q <= 1'b0;
      spawn_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      query_x_q       <= query_x_d;
      query_y_q       <= query_y_d;
      tries_q         <= tries_d;
      gap_q           <= gap_d;
      use_fb_q        <= use_fb_d;
      apple_x_q       <= apple_x_d;
      apple_y_q       <= apple_y_d;
      apple_valid_q   <= apple_valid_d;
      fallback_used_q <= fallback_used_d;
      spawn_count_q   <= spawn_count_d;
    end
  end

  assign query_x       = query_x_q;
  assign query_y       = query_y_q;
  assign query_valid   = (state_q == StQuery);
  assign busy          = (state_q != StIdle);
  assign apple_x       = apple_x_q;
  assign apple_y       = apple_y_q;
  assign apple_valid   = apple_valid_q;
  assign fallback_used = fallback_used_q;
  assign spawn_count   = spawn_count_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Bench for food_spawn_ctrl: table of directed spawns, hand-written interrupt sequences and
// randomized spawns checked against a model of the placement rules.
module tb_food_spawn_ctrl;

  localparam int MaxTries = 8;
  localparam int RetryGap = 3;

  logic       VGA_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] rand_Pos = '0;
  logic [8:0] rand_Y   = '0;
  logic       start = 1'b0, eaten = 1'b0, clear = 1'b0;
  logic [9:0] query_x;
  logic [8:0] query_y;
  logic       query_valid;
  logic       query_ready = 1'b0, query_done = 1'b0, query_hit = 1'b0;
  logic [9:0] apple_x;
  logic [8:0] apple_y;
  logic       apple_valid, busy, fallback_used;
  logic [7:0] spawn_count;

  food_spawn_ctrl dut (
    .VGA_clk      (VGA_clk),
    .rst_n        (rst_n),
    .rand_Pos     (rand_Pos),
    .rand_Y       (rand_Y),
    .start        (start),
    .eaten        (eaten),
    .clear        (clear),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_done   (query_done),
    .query_hit    (query_hit),
    .apple_x      (apple_x),
    .apple_y      (apple_y),
    .apple_valid  (apple_valid),
    .busy         (busy),
    .fallback_used(fallback_used),
    .spawn_count  (spawn_count)
  );

  always #5 VGA_clk = ~VGA_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the externally visible apple state.
  int model_cnt   = 0;
  bit model_valid = 1'b0;
  int model_ax    = 0;
  int model_ay    = 0;

  typedef struct {
    int rx;
    int ry;
    int nhits;
    int rdy_wait;
    int exp_x;
    int exp_y;
    int exp_fb;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic wait_qv();
    int n = 0;
    while (!query_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_query_valid", int'(query_valid), 1);
  endtask

  // One complete spawn with a responding checker: the first nhits queries report a hit,
  // acceptance is delayed rdy_wait cycles, and rand_mode draws a new sample after each accept.
  task automatic spawn(input int rx0, input int ry0, input int nhits, input int rdy_wait,
                       input bit rand_mode);
    int cand_x[$];
    int cand_y[$];
    int hs, ticks, wcnt, last_done, rx, ry, ex, ey, efb, ehs;
    bit pend, fin;
    rx = rx0;
    ry = ry0;
    rand_Pos = 10'(rx);
    rand_Y   = 9'(ry);
    if (model_valid) eaten = 1'b1;
    else             start = 1'b1;
    tick();
    start = 1'b0;
    eaten = 1'b0;
    chk("trigger_busy", int'(busy), 1);
    chk("trigger_apple_valid", int'(apple_valid), 0);
    hs = 0; ticks = 0; wcnt = 0; last_done = -1; pend = 1'b0; fin = 1'b0;
    while (!fin && ticks < 400) begin
      query_ready = 1'b0;
      query_done  = 1'b0;
      query_hit   = 1'b0;
      if (pend) begin
        chk("query_valid_in_wait", int'(query_valid), 0);
        query_done = 1'b1;
        query_hit  = (hs <= nhits);
        pend       = 1'b0;
        last_done  = ticks;
      end else if (query_valid) begin
        if (wcnt == 0) begin
          cand_x.push_back(clamp(rx, 20, 620));
          cand_y.push_back(clamp(ry, 20, 460));
          chk("query_x", int'(query_x), cand_x[$]);
          chk("query_y", int'(query_y), cand_y[$]);
          if (last_done >= 0) chk("gap_cycles", ticks - last_done, RetryGap + 2);
        end else begin
          chk("query_x_stable", int'(query_x), cand_x[$]);
          chk("query_y_stable", int'(query_y), cand_y[$]);
        end
        // A stray done while the candidate is still unaccepted must be ignored.
        if (wcnt == 2 && rdy_wait > 2) query_done = 1'b1;
        if (wcnt >= rdy_wait) begin
          query_ready = 1'b1;
          pend        = 1'b1;
          hs++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      tick();
      ticks++;
      if (pend && rand_mode) begin
        rx = $urandom_range(0, 1023);
        ry = $urandom_range(0, 511);
        rand_Pos = 10'(rx);
        rand_Y   = 9'(ry);
      end
      if (apple_valid) fin = 1'b1;
    end
    query_ready = 1'b0;
    query_done  = 1'b0;
    query_hit   = 1'b0;
    if (!fin) chk("spawn_timeout", 0, 1);
    if (nhits >= MaxTries) begin
      ex = 320; ey = 240; efb = 1; ehs = MaxTries;
    end else begin
      ex  = (cand_x.size() > nhits) ? cand_x[nhits] : -1;
      ey  = (cand_y.size() > nhits) ? cand_y[nhits] : -1;
      efb = 0;
      ehs = nhits + 1;
    end
    model_cnt   = (model_cnt + 1) % 256;
    model_valid = 1'b1;
    model_ax    = ex;
    model_ay    = ey;
    chk("handshakes", hs, ehs);
    chk("apple_x", int'(apple_x), ex);
    chk("apple_y", int'(apple_y), ey);
    chk("fallback_used", int'(fallback_used), efb);
    chk("spawn_count", int'(spawn_count), model_cnt);
    chk("busy_after_commit", int'(busy), 0);
    if (nhits == 0 && rdy_wait == 0) chk("min_latency", ticks, 4);
  endtask

  initial begin
    vecs[0] = '{130, 250, 0, 0, 130, 250, 0};
    vecs[1] = '{5, 470, 0, 0, 20, 460, 0};
    vecs[2] = '{700, 10, 1, 0, 620, 20, 0};
    vecs[3] = '{400, 300, 8, 0, 320, 240, 1};
    vecs[4] = '{100, 100, 0, 5, 100, 100, 0};
    vecs[5] = '{20, 460, 3, 2, 20, 460, 0};
    vecs[6] = '{1023, 511, 7, 1, 620, 460, 0};

    tick();
    tick();
    chk("reset_apple_valid", int'(apple_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_query_valid", int'(query_valid), 0);
    chk("reset_spawn_count", int'(spawn_count), 0);
    chk("reset_apple_x", int'(apple_x), 0);
    rst_n = 1'b1;
    tick();

    // eaten with no apple placed does nothing
    eaten = 1'b1;
    tick();
    eaten = 1'b0;
    chk("eaten_invalid_busy", int'(busy), 0);
    tick();
    chk("eaten_invalid_qvalid", int'(query_valid), 0);

    for (int i = 0; i < 7; i++) begin
      spawn(vecs[i].rx, vecs[i].ry, vecs[i].nhits, vecs[i].rdy_wait, 1'b0);
      chk("vec_apple_x", int'(apple_x), vecs[i].exp_x);
      chk("vec_apple_y", int'(apple_y), vecs[i].exp_y);
      chk("vec_fallback", int'(fallback_used), vecs[i].exp_fb);
      tick();
    end

    // start while an apple is placed is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid_busy", int'(busy), 0);
    chk("start_valid_apple", int'(apple_valid), 1);

    // clear during WAIT, coinciding with query_done
    eaten = 1'b1;
    tick();
    eaten = 1'b0;
    wait_qv();
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    clear = 1'b1;
    query_done = 1'b1;
    query_hit = 1'b0;
    tick();
    clear = 1'b0;
    query_done = 1'b0;
    model_valid = 1'b0;
    chk("clear_busy", int'(busy), 0);
    chk("clear_apple_valid", int'(apple_valid), 0);
    chk("clear_query_valid", int'(query_valid), 0);
    chk("clear_count_held", int'(spawn_count), model_cnt);
    chk("clear_apple_x_held", int'(apple_x), model_ax);
    query_done = 1'b1;
    tick();
    query_done = 1'b0;
    tick();
    chk("late_done_busy", int'(busy), 0);
    chk("late_done_apple_valid", int'(apple_valid), 0);

    // async reset while in GAP
    rand_Pos = 10'd300;
    rand_Y = 9'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_qv();
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    query_done = 1'b1;
    query_hit = 1'b1;
    tick();
    query_done = 1'b0;
    query_hit = 1'b0;
    tick();
    chk("gap_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_query_valid", int'(query_valid), 0);
    chk("rst_query_x", int'(query_x), 0);
    chk("rst_apple_x", int'(apple_x), 0);
    chk("rst_apple_y", int'(apple_y), 0);
    chk("rst_fallback", int'(fallback_used), 0);
    chk("rst_spawn_count", int'(spawn_count), 0);
    tick();
    rst_n = 1'b1;
    model_cnt = 0;
    model_valid = 1'b0;
    query_done = 1'b1;
    query_hit = 1'b0;
    tick();
    query_done = 1'b0;
    tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_apple_valid", int'(apple_valid), 0);

    // 256 randomized spawns from reset, crossing the 255 -> 0 wrap
    for (int i = 0; i < 256; i++) begin
      int nh;
      nh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      spawn($urandom_range(0, 1023), $urandom_range(0, 511), nh, $urandom_range(0, 2), 1'b1);
      if (i == 254) chk("count_255", int'(spawn_count), 255);
    end
    chk("count_wrap", int'(spawn_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
